dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter sharing the single-port data memory between the CPU MEM stage and one external requester (debug loader / DMA port). The CPU has priority; the external port uses a req/gnt handshake with registered read return. A starvation guard can force an external grant and stall the CPU for one cycle. Sits between the EX/MEM register outputs, the data memory and the hazard unit.

## Interface
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data width
- MAX_WAIT, 8, cycles an external request may be refused before a forced grant (legal 1..255)

- clk  in  1  system clock (divided pipeline clock)
- reset  in  1  synchronous, active-high
- cpu_rd  in  1  MEM-stage load
- cpu_wr  in  1  MEM-stage store
- cpu_addr  in  ADDR_W  MEM-stage address (ALU result)
- cpu_wdata  in  DATA_W  store data (after MEM forwarding)
- cpu_rdata  out  DATA_W  load data, combinational from mem_rdata
- cpu_stall  out  1  CPU access refused this cycle; hazard unit freezes PC, IF/ID, ID/EX, EX/MEM and inserts a bubble into MEM/WB
- ext_req  in  1  external access request, held until ext_gnt
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_gnt  out  1  access performed this cycle
- ext_rvalid  out  1  one-cycle pulse, read data valid
- ext_rdata  out  DATA_W  registered read data
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (asynchronous read)

## Operation
- cpu_req = cpu_rd | cpu_wr. cpu_rd and cpu_wr never both high (CPU guarantee; not checked).
- Per-cycle grant, combinational from inputs and registered state: grant_ext = ext_req & (!cpu_req | force). Otherwise the CPU owns the memory.
- Memory mux: grant_ext selects ext_addr/ext_wdata, mem_wr = ext_we, mem_rd = !ext_we; else cpu_* pass through. No request: mem_rd = mem_wr = 0, mem_addr/mem_wdata = CPU values.
- cpu_stall = cpu_req & grant_ext. cpu_rdata = mem_rdata always; CPU ignores it while stalled.
- ext_gnt = grant_ext. Requester may present a new request in the cycle after ext_gnt; back-to-back external grants are legal when the CPU is idle.
- Read return: on a granted external read, ext_rdata <= mem_rdata and ext_rvalid <= 1 at the next edge; ext_rvalid is 0 in every other cycle. ext_rdata holds its last value otherwise.
- Starvation counter wait_cnt (8 bits): reset to 0 on reset, on ext_gnt, or when ext_req = 0; increments each cycle ext_req = 1 and not granted; saturates at MAX_WAIT. force = (wait_cnt == MAX_WAIT) (guard builds only).
- States (encoded in wait_cnt/force): IDLE (ext_req=0), WAIT (refused, counting), FORCE (forced grant, one cycle), then IDLE/WAIT.

## Timing
- Reset values: ext_gnt 0, ext_rvalid 0, ext_rdata 0, wait_cnt 0, cpu_stall 0 (follows inputs combinationally once reset is released; while reset=1 all grant outputs forced 0, mem_rd/mem_wr 0).
- CPU access latency: 0 cycles (same-cycle read, write at edge) when not stalled.
- External access: ext_gnt in the access cycle; write committed at that edge; read data at edge+1 with ext_rvalid.
- Forced grant: with CPU busy every cycle, ext_req rising at cycle t is granted at cycle t+MAX_WAIT; cpu_stall high that one cycle only.
- Reset asserted during pending request: request dropped, counter cleared, no ext_rvalid generated for a read granted in the reset cycle.
- Reset asserted in the cycle after an external read grant: ext_rvalid suppressed (reset wins).

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined: starvation counter and forced grant as above.
- Not defined: strict CPU priority; force tied 0, no counter logic, cpu_stall constant 0; external port granted only in cycles with cpu_req = 0.

## Test plan
- CPU store 0x1234 to 0x10, ext idle -> mem_wr=1, mem_addr=0x10, cpu_stall=0, ext_gnt=0.
- CPU idle, ext read 0x10 -> ext_gnt one cycle, next cycle ext_rvalid=1, ext_rdata=0x1234.
- CPU load every cycle, ext write 0xBEEF to 0x20, MAX_WAIT=8, guard on -> ext_gnt exactly at cycle 8 after req, cpu_stall=1 that cycle only; subsequent CPU load of 0x20 returns 0xBEEF.
- Same stimulus, guard off -> ext_gnt never asserted while CPU busy; granted in first cycle cpu_req=0.
- Simultaneous cpu_rd and ext_req at wait_cnt=3 -> CPU served, ext_gnt=0, wait_cnt=4.
- Reset pulsed while wait_cnt=5 and in cycle after ext read grant -> wait_cnt=0, ext_rvalid=0, ext_rdata=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the CPU MEM stage and one
// external requester (debug loader / DMA). The CPU normally wins; the external
// port uses a req/gnt handshake and gets its read data back one edge after the
// grant. An optional starvation guard forces an external grant, stalling the
// CPU for that single cycle, once a request has been refused MAX_WAIT times.
//
// Build option:
//   DMEM_ARB_STARVE_GUARD_EN  defined  -> starvation counter + forced grant
//                             undefined -> strict CPU priority, no stall ever
//
// Parameters:
//   ADDR_W    byte address width on all ports
//   DATA_W    data width
//   MAX_WAIT  refused cycles before a forced grant (1..255)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cpu_rd/cpu_wr         MEM-stage load/store strobes (never both high)
//   cpu_addr/cpu_wdata    MEM-stage address and store data
//   cpu_rdata             load data, straight from mem_rdata
//   cpu_stall             CPU access refused this cycle (hazard unit freezes)
//   ext_req/ext_we        external request (held until ext_gnt), 1 = write
//   ext_addr/ext_wdata    external address and write data
//   ext_gnt               external access performed this cycle
//   ext_rvalid/ext_rdata  registered read return, one-cycle valid pulse
//   mem_rd/mem_wr         memory enables
//   mem_addr/mem_wdata    memory address and write data
//   mem_rdata             memory read data (asynchronous read)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  // CPU MEM stage
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // external requester
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  // data memory
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              cpu_req_s;
  logic              force_s;
  logic              grant_ext_s;
  logic              ext_rvalid_r;
  logic [DATA_W-1:0] ext_rdata_r;

  assign cpu_req_s = cpu_rd | cpu_wr;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  // The guard state lives entirely in wait_cnt: 0 with no request is IDLE,
  // counting while refused is WAIT, reaching MAX_WAIT is the one-cycle FORCE.
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_nxt_s;

  // Next value of the starvation counter
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    if (!ext_req || grant_ext_s) begin
      wait_cnt_nxt_s = 8'd0;
    end else if (wait_cnt_r != MAX_WAIT_C) begin
      wait_cnt_nxt_s = wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 8'd0;
    end else begin
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // The counter only reaches MAX_WAIT while a request is still pending, and
  // the resulting grant clears it, so FORCE never lasts more than one cycle.
  assign force_s = (wait_cnt_r == MAX_WAIT_C);
`else
  assign force_s = 1'b0;
`endif

  // Reset masks the grant so no access and no read return start in a reset
  // cycle, even if the requester still holds ext_req.
  assign grant_ext_s = ~reset & ext_req & (~cpu_req_s | force_s);
  assign ext_gnt     = grant_ext_s;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  assign cpu_stall = cpu_req_s & grant_ext_s;
`else
  assign cpu_stall = 1'b0;
`endif

  assign cpu_rdata = mem_rdata;

  // Memory port steering between the external requester and the CPU
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (reset) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
    end else if (grant_ext_s) begin
      mem_rd    = ~ext_we;
      mem_wr    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else begin
      mem_rd = cpu_rd;
      mem_wr = cpu_wr;
    end
  end

  // Registered read return for granted external reads
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_rvalid_r <= 1'b0;
      ext_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      ext_rvalid_r <= grant_ext_s & ~ext_we;
      if (grant_ext_s && !ext_we) begin
        ext_rdata_r <= mem_rdata;
      end
    end
  end

  // A reset arriving in the cycle after a read grant suppresses the pending
  // pulse immediately rather than letting it show for that cycle.
  assign ext_rvalid = ext_rvalid_r & ~reset;
  assign ext_rdata  = ext_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// CPU/external traffic. A behavioural model (shadow memory, pending-request
// age, registered read return) predicts every DUT output each cycle.
// Honours DMEM_ARB_STARVE_GUARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 8;

  logic          clk;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory seen by the DUT: 256 words, asynchronous read
  logic          mem_clr;
  logic [DW-1:0] mem_array [256];
  assign mem_rdata = mem_array[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_array[i] <= '0;
    end else if (mem_wr) begin
      mem_array[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  logic          exp_rvalid_q;
  logic [DW-1:0] exp_rdata_q;
  int            cyc;
  int            pend_start;   // cycle in which the current ext request began
  logic          last_gx;

  // Observations from the last cycle, for directed checks
  logic          obs_gnt, obs_stall, obs_rvalid, obs_mem_wr;
  logic [AW-1:0] obs_mem_addr;
  logic [DW-1:0] obs_rdata, obs_cpu_rdata;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check outputs at negedge, advance the model at posedge.
  task automatic cycle();
    logic          creq, frc, gx;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    @(negedge clk);
    creq = cpu_rd | cpu_wr;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    frc = ext_req && ((cyc - pend_start) == MW);
`else
    frc = 1'b0;
`endif
    gx = !reset && ext_req && (!creq || frc);
    ea = gx ? ext_addr : cpu_addr;
    ew = gx ? ext_wdata : cpu_wdata;
    check("mem_rd",     mem_rd,     reset ? 1'b0 : (gx ? !ext_we : cpu_rd));
    check("mem_wr",     mem_wr,     reset ? 1'b0 : (gx ? ext_we : cpu_wr));
    check("mem_addr",   mem_addr,   ea);
    check("mem_wdata",  mem_wdata,  ew);
    check("ext_gnt",    ext_gnt,    gx);
    check("cpu_stall",  cpu_stall,  gx && creq);
    check("cpu_rdata",  cpu_rdata,  ref_mem[ea[9:2]]);
    check("ext_rvalid", ext_rvalid, exp_rvalid_q && !reset);
    check("ext_rdata",  ext_rdata,  exp_rdata_q);
    obs_gnt = ext_gnt; obs_stall = cpu_stall; obs_rvalid = ext_rvalid;
    obs_rdata = ext_rdata; obs_mem_wr = mem_wr; obs_mem_addr = mem_addr;
    obs_cpu_rdata = cpu_rdata;
    @(posedge clk);
    if (reset) begin
      exp_rvalid_q = 1'b0;
      exp_rdata_q  = '0;
    end else begin
      exp_rvalid_q = gx && !ext_we;
      if (gx && !ext_we) exp_rdata_q = ref_mem[ext_addr[9:2]];
      if (gx ? ext_we : cpu_wr) ref_mem[ea[9:2]] = ew;
    end
    if (reset || !ext_req || gx) pend_start = cyc + 1;
    last_gx = gx;
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    cyc = 0; pend_start = 0; last_gx = 1'b0;
    exp_rvalid_q = 1'b0; exp_rdata_q = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    idle_inputs();
    reset = 1'b1; mem_clr = 1'b1;
    cycle(); cycle();
    check("rst_gnt", obs_gnt, 1'b0);
    check("rst_rvalid", obs_rvalid, 1'b0);
    check("rst_rdata", obs_rdata, 32'h0);
    reset = 1'b0; mem_clr = 1'b0;
    cycle();

    // CPU store, external idle
    cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
    cycle();
    check("st_mem_wr", obs_mem_wr, 1'b1);
    check("st_addr", obs_mem_addr, 32'h10);
    check("st_stall", obs_stall, 1'b0);
    check("st_gnt", obs_gnt, 1'b0);

    // CPU idle, external read of the stored word
    idle_inputs();
    ext_req = 1'b1; ext_addr = 32'h10;
    cycle();
    check("rd_gnt", obs_gnt, 1'b1);
    ext_req = 1'b0;
    cycle();
    check("rd_rvalid", obs_rvalid, 1'b1);
    check("rd_rdata", obs_rdata, 32'h1234);
    cycle();
    check("rd_rvalid_pulse", obs_rvalid, 1'b0);

    // CPU loads every cycle while external write waits
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'hBEEF;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k <= MW; k++) begin
      cycle();
      check("force_gnt", obs_gnt, k == MW);
      check("force_stall", obs_stall, k == MW);
    end
    ext_req = 1'b0;
    cycle();
    check("post_force_stall", obs_stall, 1'b0);
`else
    for (int k = 0; k <= MW + 3; k++) begin
      cycle();
      check("strict_gnt", obs_gnt, 1'b0);
      check("strict_stall", obs_stall, 1'b0);
    end
    cpu_rd = 1'b0;
    cycle();
    check("strict_idle_gnt", obs_gnt, 1'b1);
    ext_req = 1'b0;
`endif
    cpu_rd = 1'b1; cpu_addr = 32'h20;
    cycle();
    check("ld_beef", obs_cpu_rdata, 32'hBEEF);

    // Reset while a request has been waiting five cycles
    cpu_addr = 32'h44;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    for (int k = 0; k < 5; k++) cycle();
    reset = 1'b1; ext_req = 1'b0;
    cycle();
    check("rst_wait_gnt", obs_gnt, 1'b0);
    reset = 1'b0;
    ext_req = 1'b1;
    for (int k = 0; k <= MW; k++) cycle();   // model tracks the restarted age
    ext_req = 1'b0;
    cycle();

    // Reset in the cycle after an external read grant
    idle_inputs();
    ext_req = 1'b1; ext_addr = 32'h20;
    cycle();
    check("rr_gnt", obs_gnt, 1'b1);
    ext_req = 1'b0; reset = 1'b1;
    cycle();
    check("rr_rvalid_rst", obs_rvalid, 1'b0);
    reset = 1'b0;
    cycle();
    check("rr_rvalid_after", obs_rvalid, 1'b0);
    check("rr_rdata_after", obs_rdata, 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 3);
      cpu_rd = (r == 1) || (r == 3);
      cpu_wr = (r == 2);
      cpu_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      cpu_wdata = $urandom;
      if (!ext_req || last_gx) begin
        ext_req = ($urandom_range(0, 1) == 1);
        ext_we  = ($urandom_range(0, 1) == 1);
        ext_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        ext_wdata = $urandom;
      end
      reset = ($urandom_range(0, 49) == 0);
      if (reset) ext_req = 1'b0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
